// File: rtl/xpmwrap_fifo_rd_stream.sv
// xpmwrap_fifo_rd_stream
// Turns the read port of a standard-mode FIFO (data one cycle after rd_en)
// into a ready/valid stream with packet framing. A two-entry skid buffer
// absorbs the read latency, so the FIFO can be read every cycle while the
// sink accepts, and reading stops in time when the sink stalls.
// While the FIFO reports read-side reset busy, the block parks in WAIT_RST
// and throws away anything it had buffered or had in flight.

module xpmwrap_fifo_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 16
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic                  fifo_rd_rst_busy,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [15:0]           beat_cnt,
    output logic [15:0]           pkt_cnt,
    output logic                  err_underflow,
    input  logic                  clr_err
);

    // Index of the final beat of a packet.
    localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

    typedef enum logic {
        WAIT_RST = 1'b0,
        RUN      = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Buffer occupancy and the word requested last cycle.
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;

    // head holds the oldest word, tail the younger one when occ==2.
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    logic [15:0]           beat_cnt_q, beat_cnt_d;
    logic [15:0]           pkt_cnt_q, pkt_cnt_d;
    logic                  err_q, err_d;

    logic                  pop;
    logic                  push;
    logic                  flush;
    logic [2:0]            level_after;

    // State register.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: run whenever the FIFO read side is out of reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_RST: if (!fifo_rd_rst_busy) state_d = RUN;
            RUN:      if (fifo_rd_rst_busy)  state_d = WAIT_RST;
            default:  state_d = WAIT_RST;
        endcase
    end

    // Outputs: stream handshake and FIFO read request. A read is issued
    // only if the word it returns is guaranteed a free buffer slot, counting
    // the word already in flight and the beat leaving this cycle.
    always_comb begin
        m_tvalid    = (state_q == RUN) && (occ_q != 2'd0);
        pop         = m_tvalid && m_tready;
        level_after = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en  = (state_q == RUN) && !fifo_empty && !fifo_rd_rst_busy
                      && (level_after < 3'd2);
        m_tdata     = head_q;
        m_tlast     = m_tvalid && (beat_cnt_q == LAST_IDX);
    end

    assign beat_cnt      = beat_cnt_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign err_underflow = err_q;

    // Buffer, in-flight tracking, beat/packet counters and sticky error.
    always_comb begin
        push       = inflight_q;
        flush      = fifo_rd_rst_busy;
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = fifo_rd_en;
        beat_cnt_d = beat_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;

        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = fifo_dout;
                end else begin
                    tail_d = fifo_dout;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word goes behind whatever
                // remains after the head leaves.
                if (occ_q == 2'd1) begin
                    head_d = fifo_dout;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_dout;
                end
            end
            default: begin
            end
        endcase

        // A beat the sink already took still completes its packet count.
        if (pop) begin
            if (m_tlast) begin
                beat_cnt_d = 16'd0;
                pkt_cnt_d  = pkt_cnt_q + 16'd1;
            end else begin
                beat_cnt_d = beat_cnt_q + 16'd1;
            end
        end

        // Read-side reset: buffered and in-flight words are stale.
        if (flush) begin
            occ_d      = 2'd0;
            inflight_d = 1'b0;
            beat_cnt_d = 16'd0;
        end

        // Setting wins over clearing so an underflow is never lost.
        if (fifo_underflow) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            beat_cnt_q <= 16'd0;
            pkt_cnt_q  <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_q      <= err_d;
        end
    end

    // The read throttle must keep the buffer from ever overfilling.
    occ_bound_a: assert property (@(posedge rd_clk) disable iff (!rst_n)
        occ_q <= 2'd2);
    level_bound_a: assert property (@(posedge rd_clk) disable iff (!rst_n)
        ({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2);

endmodule

// File: tb/tb_xpmwrap_fifo_rd_stream.sv
// Bench for xpmwrap_fifo_rd_stream: a queue-based FIFO model feeds the DUT;
// every word read from the FIFO is expected at the stream in read order,
// except words discarded by a read-side reset or a block reset.
module tb_xpmwrap_fifo_rd_stream;

    logic        rd_clk;
    logic        rst_n;
    logic [31:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic        busy;
    logic        uf;
    logic        rd_en;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [15:0] beat_cnt;
    logic [15:0] pkt_cnt;
    logic        err;
    logic        clr_err;

    logic        d1_rd_en;
    logic [31:0] d1_tdata;
    logic        d1_tvalid;
    logic        d1_tlast;
    logic [15:0] d1_beat;
    logic [15:0] d1_pkt;
    logic        d1_err;

    xpmwrap_fifo_rd_stream #(.DATA_WIDTH(32), .PKT_LEN(4)) dut (
        .rd_clk(rd_clk), .rst_n(rst_n), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .fifo_rd_rst_busy(busy),
        .fifo_underflow(uf), .fifo_rd_en(rd_en), .m_tdata(tdata),
        .m_tvalid(tvalid), .m_tready(tready), .m_tlast(tlast),
        .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt), .err_underflow(err),
        .clr_err(clr_err));

    // Same stimulus, single-beat packets.
    xpmwrap_fifo_rd_stream #(.DATA_WIDTH(32), .PKT_LEN(1)) dut1 (
        .rd_clk(rd_clk), .rst_n(rst_n), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .fifo_rd_rst_busy(busy),
        .fifo_underflow(uf), .fifo_rd_en(d1_rd_en), .m_tdata(d1_tdata),
        .m_tvalid(d1_tvalid), .m_tready(tready), .m_tlast(d1_tlast),
        .beat_cnt(d1_beat), .pkt_cnt(d1_pkt), .err_underflow(d1_err),
        .clr_err(clr_err));

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total_cnt = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int          beat_m = 0;
    int          pkt_m = 0;
    bit          force_empty = 1'b0;
    bit          rd_pend = 1'b0;
    logic [31:0] rd_word;
    int          rd_total = 0;
    int          pop_total = 0;
    bit          mon_pop;
    logic [31:0] mon_w;
    logic [31:0] pop_tmp;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    // FIFO model: data one cycle after the read; flags update on the edge.
    always @(posedge rd_clk) begin
        if (rd_pend) begin
            rd_pend = 1'b0;
            pop_tmp = fifo_q.pop_front();
            fifo_dout <= rd_word;
        end
        fifo_empty <= (fifo_q.size() == 0) || force_empty;
    end

    // Mid-cycle monitor and scoreboard.
    always @(negedge rd_clk) begin
        if (rst_n) begin
            mon_pop = tvalid && tready;
            if (rd_en) begin
                check("rd_en_room", 32'((exp_q.size() - int'(mon_pop)) < 2), 32'd1);
                check("rd_en_nonempty", 32'(fifo_q.size() > 0), 32'd1);
            end
            if (mon_pop) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("tdata", tdata, mon_w);
                end
                check("beat_cnt", 32'(beat_cnt), 32'(beat_m));
                check("tlast", 32'(tlast), 32'(beat_m == 3));
                if (beat_m == 3) begin
                    beat_m = 0;
                    pkt_m  = (pkt_m + 1) % 65536;
                end else begin
                    beat_m++;
                end
                pop_total++;
            end
            check("len1_rd_en", 32'(d1_rd_en), 32'(rd_en));
            if (d1_tvalid) begin
                check("len1_tlast", 32'(d1_tlast), 32'd1);
                check("len1_tdata", d1_tdata, tdata);
            end
            if (rd_en) begin
                exp_q.push_back(fifo_q[0]);
                rd_word = fifo_q[0];
                rd_pend = 1'b1;
                rd_total++;
            end
            if (busy) begin
                exp_q.delete();
                beat_m = 0;
            end
        end
    end

    task automatic wait_drain(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !tvalid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(done), 32'd1);
    endtask

    int          rdn, popn, first_rd, last_rd, first_pop, last_pop;
    int          rd0, pop0, pushed, pkt_snap;
    logic [31:0] w0;
    bit          got;

    initial begin
        rst_n   = 1'b0;
        tready  = 1'b0;
        busy    = 1'b0;
        uf      = 1'b0;
        clr_err = 1'b0;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(32'(i));
        repeat (3) tick();

        // Reset values, with data waiting in the FIFO.
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_beat", 32'(beat_cnt), 32'd0);
        check("rst_pkt", 32'(pkt_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Streaming: 8 preloaded words, sink always ready.
        tready = 1'b1;
        rst_n  = 1'b1;
        rdn = 0; popn = 0; first_rd = -1; last_rd = -1; first_pop = -1; last_pop = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge rd_clk);
            if (rd_en) begin
                rdn++;
                if (first_rd < 0) first_rd = i;
                last_rd = i;
            end
            if (tvalid && tready) begin
                popn++;
                if (first_pop < 0) first_pop = i;
                last_pop = i;
            end
        end
        check("stream_rd_count", 32'(rdn), 32'd8);
        check("stream_rd_span", 32'(last_rd - first_rd), 32'd7);
        check("stream_pop_count", 32'(popn), 32'd8);
        check("stream_pop_span", 32'(last_pop - first_pop), 32'd7);
        check("stream_latency", 32'(first_pop - first_rd), 32'd2);
        check("stream_pkt_cnt", 32'(pkt_cnt), 32'd2);
        tick();

        // Backpressure: two reads fill the buffer, head word held.
        tready = 1'b0;
        rd0 = rd_total;
        pop0 = pop_total;
        for (int i = 0; i < 5; i++) fifo_q.push_back($urandom);
        w0 = fifo_q[0];
        repeat (12) tick();
        check("bp_rd_pulses", 32'(rd_total - rd0), 32'd2);
        check("bp_tvalid", 32'(tvalid), 32'd1);
        check("bp_tdata", tdata, w0);
        repeat (3) tick();
        check("bp_tdata_hold", tdata, w0);
        check("bp_tlast_hold", 32'(tlast), 32'(beat_m == 3));
        check("bp_rd_still", 32'(rd_total - rd0), 32'd2);
        tready = 1'b1;
        wait_drain("bp_drain", 60);
        check("bp_pops", 32'(pop_total - pop0), 32'd5);

        // Read-side reset busy in the middle of a packet.
        for (int i = 0; i < 8; i++) fifo_q.push_back($urandom);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (beat_m == 2) begin
                got = 1'b1;
                break;
            end
        end
        tready = 1'b0;
        check("busy_reach_beat2", 32'(got), 32'd1);
        repeat (5) tick();
        check("busy_pre_level", 32'(exp_q.size()), 32'd2);
        check("busy_pre_beat", 32'(beat_cnt), 32'd2);
        check("busy_pre_tvalid", 32'(tvalid), 32'd1);
        pkt_snap = pkt_m;
        busy = 1'b1;
        tick();
        check("busy_tvalid", 32'(tvalid), 32'd0);
        check("busy_beat", 32'(beat_cnt), 32'd0);
        check("busy_rd_en", 32'(rd_en), 32'd0);
        check("busy_pkt", 32'(pkt_cnt), 32'(pkt_snap));
        repeat (2) tick();
        check("busy_wait_tvalid", 32'(tvalid), 32'd0);
        busy = 1'b0;
        tready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tvalid) begin
                got = 1'b1;
                break;
            end
        end
        check("busy_resume", 32'(got), 32'd1);
        check("busy_resume_beat", 32'(beat_cnt), 32'd0);
        check("busy_resume_pkt", 32'(pkt_cnt), 32'(pkt_snap));
        wait_drain("busy_drain", 60);

        // Sticky underflow error.
        uf = 1'b1;
        tick();
        uf = 1'b0;
        check("err_set", 32'(err), 32'd1);
        repeat (2) tick();
        check("err_hold", 32'(err), 32'd1);
        uf = 1'b1;
        clr_err = 1'b1;
        tick();
        uf = 1'b0;
        clr_err = 1'b0;
        check("err_set_wins", 32'(err), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("err_clear", 32'(err), 32'd0);

        // Random ready and FIFO availability, 1000 words.
        pushed = 0;
        pop0 = pop_total;
        for (int i = 0; i < 20000; i++) begin
            if (pop_total - pop0 >= 1000) break;
            tready = 1'($urandom % 2);
            if ($urandom % 8 == 0) force_empty = !force_empty;
            if (pushed < 1000 && fifo_q.size() < 6 && ($urandom % 2) == 1) begin
                fifo_q.push_back($urandom);
                pushed++;
            end
            tick();
        end
        force_empty = 1'b0;
        tready = 1'b1;
        check("rand_words", 32'(pop_total - pop0), 32'd1000);
        wait_drain("rand_drain", 40);
        check("rand_pkt", 32'(pkt_cnt), 32'(pkt_m));

        // Asynchronous reset between edges, mid-stream with the error set.
        uf = 1'b1;
        tick();
        uf = 1'b0;
        for (int i = 0; i < 6; i++) fifo_q.push_back($urandom);
        repeat (4) tick();
        check("ar_pre_tvalid", 32'(tvalid), 32'd1);
        @(posedge rd_clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_rd_en", 32'(rd_en), 32'd0);
        check("ar_tvalid", 32'(tvalid), 32'd0);
        check("ar_tlast", 32'(tlast), 32'd0);
        check("ar_tdata", tdata, 32'd0);
        check("ar_beat", 32'(beat_cnt), 32'd0);
        check("ar_pkt", 32'(pkt_cnt), 32'd0);
        check("ar_err", 32'(err), 32'd0);
        exp_q.delete();
        fifo_q.delete();
        beat_m = 0;
        pkt_m  = 0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) fifo_q.push_back($urandom);
        wait_drain("ar_drain", 40);
        check("ar_pkt_after", 32'(pkt_cnt), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/xpmwrap_fifo_rd_stream.md
XPMWRAP_FIFO_RD_STREAM -- requirements
Module: xpmwrap_fifo_rd_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 32: FIFO dout and m_tdata width.
REQ-002 Parameter PKT_LEN, default 16: beats per packet; m_tlast on the final beat; legal range 1..65535.
REQ-003 rd_clk  in  1: single clock, the FIFO read clock.
REQ-004 rst_n  in  1: reset, asynchronous assert, active-low.
REQ-005 fifo_dout  in  DATA_WIDTH: FIFO read data, std mode, valid exactly 1 cycle after the fifo_rd_en it answers.
REQ-006 fifo_empty  in  1: FIFO empty flag.
REQ-007 fifo_rd_rst_busy  in  1: FIFO read-domain reset busy.
REQ-008 fifo_underflow  in  1: FIFO underflow flag.
REQ-009 fifo_rd_en  out  1: FIFO read enable.
REQ-010 m_tdata  out  DATA_WIDTH: stream data.
REQ-011 m_tvalid  out  1: stream valid.
REQ-012 m_tready  in  1: stream ready from the sink.
REQ-013 m_tlast  out  1: last beat of packet.
REQ-014 beat_cnt  out  16: beat index of the current head word within its packet.
REQ-015 pkt_cnt  out  16: completed packets, wraps at 2^16.
REQ-016 err_underflow  out  1: sticky underflow error.
REQ-017 clr_err  in  1: synchronous clear of err_underflow.

Function
REQ-018 The FSM SHALL have two states: WAIT_RST and RUN.
REQ-019 The FSM SHALL move from WAIT_RST to RUN on the first cycle fifo_rd_rst_busy=0, and from RUN to WAIT_RST on any cycle fifo_rd_rst_busy=1.
REQ-020 The block SHALL hold a 2-entry output buffer (occ 0..2) and an in-flight flag (inflight = fifo_rd_en registered).
REQ-021 pop SHALL equal m_tvalid & m_tready.
REQ-022 fifo_rd_en SHALL be combinational: state==RUN & !fifo_empty & !fifo_rd_rst_busy & (occ + inflight - pop) < 2.
REQ-023 When inflight=1, fifo_dout SHALL be written into the buffer that cycle; a simultaneous push and pop SHALL leave occ unchanged.
REQ-024 m_tvalid SHALL equal (occ > 0); m_tdata SHALL be the oldest entry; the buffer SHALL preserve FIFO order.
REQ-025 With m_tvalid=1 and m_tready=0, m_tdata and m_tlast SHALL stay stable.
REQ-026 With the FIFO never empty and m_tready held at 1, the block SHALL sustain 1 beat/cycle after a 2-cycle fill latency (fifo_rd_en to m_tvalid).
REQ-027 m_tlast SHALL equal (beat_cnt == PKT_LEN-1).
REQ-028 beat_cnt SHALL increment on each pop; on a pop with m_tlast=1 it SHALL wrap to 0 and pkt_cnt SHALL increment by 1.
REQ-029 When PKT_LEN=1, every beat SHALL carry m_tlast=1.
REQ-030 err_underflow SHALL set on fifo_underflow=1 and clear on clr_err=1; if both occur in the same cycle, set SHALL win.
REQ-031 On the RUN->WAIT_RST transition, the block SHALL on the next edge discard the buffer (occ=0), discard the in-flight word, and clear beat_cnt to 0; pkt_cnt and err_underflow SHALL be kept.
REQ-032 In WAIT_RST, fifo_rd_en and m_tvalid SHALL be 0.
REQ-033 Overflow of the output buffer SHALL be impossible by construction; an assertion SHALL check occ <= 2.

Reset
REQ-034 rst_n=0 SHALL asynchronously force: state=WAIT_RST, occ=0, inflight=0, fifo_rd_en=0, m_tvalid=0, m_tlast=0, m_tdata=0, beat_cnt=0, pkt_cnt=0, err_underflow=0.
REQ-035 Reset deassertion SHALL take effect on the next rd_clk edge; the block SHALL leave WAIT_RST only per REQ-019.

Verification
REQ-036 Streaming: PKT_LEN=4, 8 words 0x1..0x8 preloaded, m_tready=1 -> fifo_rd_en high 8 cycles; m_tdata 0x1..0x8 on 8 consecutive cycles; m_tlast on 0x4 and 0x8; pkt_cnt=2.
REQ-037 Backpressure: m_tready=0 with words available -> exactly 2 fifo_rd_en pulses, occ=2, m_tdata held at the first word; after m_tready=1 all words arrive in order with no loss or duplication.
REQ-038 Random ready: m_tready random 50%, FIFO empty toggled randomly, 1000 words -> scoreboard exact order match, no extra fifo_rd_en while occ+inflight=2.
REQ-039 Busy mid-packet: fifo_rd_rst_busy=1 at beat 2 with occ=2 -> next cycle m_tvalid=0 and beat_cnt=0; after busy drops, the first beat has beat_cnt=0 and pkt_cnt is unchanged.
REQ-040 Error: fifo_underflow pulse -> err_underflow=1 held; clr_err and fifo_underflow in the same cycle -> stays 1; clr_err alone -> 0.
REQ-041 Async reset: rst_n=0 mid-stream, asserted between clock edges -> all outputs at REQ-034 values before the next edge.
